rr_sep_alloc: RTL
=================

Name: rr_sep_alloc

Overview:
Parametrised, input-first separable allocator; successor to the fixed 4x4 priority selector.
- Matches N_IN requesters to N_OUT resources using per-input and per-output round-robin arbiters.
- Registered grant matrix; grants can be held (locked) across cycles for multi-flit packets.
- Sits between router input buffers and the crossbar/switch-traversal stage.

Parameters:
N_IN, 4, number of requesting inputs (>=2)
N_OUT, 4, number of outputs/resources (>=2)
HOLD_EN, 1, 1 = hold[] honoured; 0 = hold[] ignored, every grant lasts one cycle

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  [N_IN-1:0][N_OUT-1:0]  req[i][o]=1: input i requests output o; any number of bits per row
hold  input  N_IN  hold[i]=1: input i keeps its current grant next cycle
gnt  output  [N_IN-1:0][N_OUT-1:0]  registered grant matrix; at most one 1 per row and per column
gnt_valid  output  N_IN  gnt_valid[i] = |gnt[i], registered
out_busy  output  N_OUT  out_busy[o] = |column o of gnt, registered

Behaviour:
- Reset (reset=0, asynchronous): gnt, gnt_valid, out_busy = 0; all pointers in_ptr[i] and out_ptr[o] = 0; no locks. Applies mid-operation: held grants are dropped immediately.
- Latency: gnt after rising edge k reflects req, hold and the previous gnt sampled at edge k. Exactly one cycle.
- Lock determination (combinational from current state): locked[i] = HOLD_EN & hold[i] & |gnt[i].
  - A locked row keeps its gnt bits unchanged next cycle, regardless of req[i].
  - A locked output column is unavailable to every other input.
  - hold[i] with gnt[i]=0 has no effect.
- Stage 1, per unlocked input i:
  - Mask req[i] with outputs not locked by other inputs.
  - Pick the first set bit at index >= in_ptr[i], wrapping modulo N_OUT.
  - Result: at most one candidate output per input.
- Stage 2, per unlocked output o:
  - Among the inputs whose stage-1 pick is o, choose the first at index >= out_ptr[o], wrapping modulo N_IN.
- Next gnt = locked rows (unchanged) OR new stage-2 grants. Single iteration: inputs that lose stage 2 get no grant this cycle, even if another output is free.
- Pointer update only on a new (non-held) grant (i,o):
  - in_ptr[i] <= (o+1) mod N_OUT.
  - out_ptr[o] <= (i+1) mod N_IN.
  - Losers and held grants leave pointers unchanged.
- Pointers are $clog2 width; wrap is explicit and must be correct for non-power-of-2 N_IN/N_OUT.
- Release timing: when hold[i] falls while locked, the row and its output re-enter arbitration in that same cycle. The old output may be re-granted to i only via normal round-robin.
- Simultaneous events:
  - req row all zero: no grant for that input.
  - All inputs request one output: one winner per cycle; every requester is served within N_IN cycles.
- No combinational path from req/hold to outputs.
- Invariant (assert in RTL/bench): no row or column of gnt has more than one bit set.

Test Plan:
1. Reset then idle: reset=0 for 5 edges, req=0 -> gnt=0, gnt_valid=0, out_busy=0; assert reset mid-grant -> gnt=0 with no clock edge.
2. N=4, pointers 0, req rows = {0:4'b1111, 1:4'b1110, 2:4'b1110, 3:4'b1110}, hold=0.
   - Edge 1 -> gnt[0]=4'b0001, gnt[1]=4'b0010, gnt[2]=gnt[3]=0.
   - Edge 2 -> gnt[1]=4'b0100, gnt[2]=4'b0010, gnt[0]=gnt[3]=0.
3. Fairness: all 4 inputs req=4'b0001 continuously -> output 0 granted to inputs 0,1,2,3,0,... on consecutive cycles.
4. Hold: input 2 granted output 3, hold[2]=1 for 4 cycles while inputs 0,1 also request output 3.
   - gnt[2]=4'b1000 for all 4 cycles; input 2 keeps the grant even with req[2]=0.
   - Cycle after hold[2]=0: output 3 goes to input 0 (out_ptr[3]=3, wraps to 0).
5. HOLD_EN=0 build: same stimulus as scenario 4 -> hold ignored, output 3 rotates among 0,1,2 each cycle.
6. Non-square N_IN=5, N_OUT=3, random req/hold for 10k cycles:
   - gnt one-hot per row and column.
   - Pointers stay in range.
   - No requester starves beyond N_IN*N_OUT cycles without hold.

Source files
------------

// File: rtl/rr_sep_alloc.sv
// rtl/rr_sep_alloc.sv - input-first separable round-robin allocator with registered, holdable grants
// Stage 1 picks one output per input, stage 2 picks one input per output; held rows bypass both.
module rr_sep_alloc #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IN-1:0][N_OUT-1:0]   req,
  input  logic [N_IN-1:0]              hold,
  output logic [N_IN-1:0][N_OUT-1:0]   gnt,
  output logic [N_IN-1:0]              gnt_valid,
  output logic [N_OUT-1:0]             out_busy
);

  localparam int IPW = $clog2(N_OUT);
  localparam int OPW = $clog2(N_IN);

  logic [N_IN-1:0][N_OUT-1:0] gnt_q, gnt_d;
  logic [N_IN-1:0]            gnt_valid_q, gnt_valid_d;
  logic [N_OUT-1:0]           out_busy_q, out_busy_d;
  logic [IPW-1:0]             in_ptr_q  [N_IN];
  logic [IPW-1:0]             in_ptr_d  [N_IN];
  logic [OPW-1:0]             out_ptr_q [N_OUT];
  logic [OPW-1:0]             out_ptr_d [N_OUT];

  logic [N_IN-1:0]            locked;
  logic [N_OUT-1:0]           out_locked;
  logic [N_IN-1:0][N_OUT-1:0] pick;
  logic [N_IN-1:0][N_OUT-1:0] new_gnt;

  always_comb begin : lock_c
    locked     = '0;
    out_locked = '0;
    for (int i = 0; i < N_IN; i++) begin
      locked[i] = HOLD_EN && hold[i] && (|gnt_q[i]);
      if (locked[i]) out_locked = out_locked | gnt_q[i];
    end
  end

  // Round-robin search in two passes: indices at/after the pointer first, then wrap to the low ones.
  always_comb begin : stage1_c
    logic hit;
    pick = '0;
    hit  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      hit = 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        if (!hit && !locked[i] && req[i][o] && !out_locked[o] && o >= int'(in_ptr_q[i])) begin
          pick[i][o] = 1'b1;
          hit        = 1'b1;
        end
      end
      for (int o = 0; o < N_OUT; o++) begin
        if (!hit && !locked[i] && req[i][o] && !out_locked[o]) begin
          pick[i][o] = 1'b1;
          hit        = 1'b1;
        end
      end
    end
  end

  always_comb begin : stage2_c
    logic hit;
    new_gnt = '0;
    hit     = 1'b0;
    for (int o = 0; o < N_OUT; o++) begin
      hit = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        if (!hit && !out_locked[o] && pick[i][o] && i >= int'(out_ptr_q[o])) begin
          new_gnt[i][o] = 1'b1;
          hit           = 1'b1;
        end
      end
      for (int i = 0; i < N_IN; i++) begin
        if (!hit && !out_locked[o] && pick[i][o]) begin
          new_gnt[i][o] = 1'b1;
          hit           = 1'b1;
        end
      end
    end
  end

  always_comb begin : next_c
    gnt_d       = '0;
    gnt_valid_d = '0;
    out_busy_d  = '0;
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    for (int i = 0; i < N_IN; i++) begin
      gnt_d[i]       = locked[i] ? gnt_q[i] : new_gnt[i];
      gnt_valid_d[i] = |gnt_d[i];
      out_busy_d     = out_busy_d | gnt_d[i];
    end
    // Only fresh grants advance pointers; wrap is explicit so non-power-of-2 sizes stay in range.
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (new_gnt[i][o]) begin
          in_ptr_d[i]  = (o == N_OUT - 1) ? '0 : IPW'(o + 1);
          out_ptr_d[o] = (i == N_IN - 1)  ? '0 : OPW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      gnt_valid_q <= '0;
      out_busy_q  <= '0;
      for (int i = 0; i < N_IN; i++)  in_ptr_q[i]  <= '0;
      for (int o = 0; o < N_OUT; o++) out_ptr_q[o] <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      out_busy_q  <= out_busy_d;
      for (int i = 0; i < N_IN; i++)  in_ptr_q[i]  <= in_ptr_d[i];
      for (int o = 0; o < N_OUT; o++) out_ptr_q[o] <= out_ptr_d[o];
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign out_busy  = out_busy_q;

endmodule
